cache_refill_arbiter: RTL and testbench

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

---
 rtl/cache_refill_arbiter_pkg.sv | 22 ++
 rtl/cache_refill_arbiter_if.sv | 30 +++
 rtl/cache_refill_arbiter_rr_arbiter2.sv | 30 +++
 rtl/cache_refill_arbiter.sv | 113 +++++++++++
 tb/tb_cache_refill_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared constants, owner encoding and refill state enum for the refill arbiter.
package cache_pkg;
  localparam int ADDR_WIDTH  = 32;
  localparam int LINE_WIDTH  = 512;
  localparam int OFFSET_BITS = 6;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } refill_state_e;

  // Clear the byte-offset bits so the address points at the start of a line.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return a & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  endfunction
endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Requester, memory and refill-FIFO handshake bundle of the refill arbiter.
interface cache_refill_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512
);
  logic                  ic_req, dc_req;
  logic [ADDR_WIDTH-1:0] ic_addr, dc_addr;
  logic                  ic_ack, dc_ack;
  logic                  ic_done, dc_done;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready, mem_rvalid;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  fifo_full, fifo_wr_en, fifo_wr_owner;
  logic [LINE_WIDTH-1:0] fifo_wr_data;

  // Arbiter side.
  modport master (
    input  ic_req, dc_req, ic_addr, dc_addr, mem_ready, mem_rvalid, mem_rdata, fifo_full,
    output ic_ack, dc_ack, ic_done, dc_done, mem_req, mem_addr,
           fifo_wr_en, fifo_wr_data, fifo_wr_owner
  );

  // Caches / memory / FIFO side.
  modport slave (
    output ic_req, dc_req, ic_addr, dc_addr, mem_ready, mem_rvalid, mem_rdata, fifo_full,
    input  ic_ack, dc_ack, ic_done, dc_done, mem_req, mem_addr,
           fifo_wr_en, fifo_wr_data, fifo_wr_owner
  );
endinterface

// File: rtl/cache_refill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = icache, bit 1 = dcache.
module rr_arbiter2
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       owner_i,
  output logic [1:0] grant_o
);
  logic last_q;

  // Remember the last served owner; reset pretends dcache went last so icache wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_q <= OWN_DC;
    else if (update_i) last_q <= owner_i;
  end

  // One-hot grant; on contention the side not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == OWN_IC) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/cache_refill_arbiter.sv
// Serialises icache/dcache line misses into single memory reads and FIFO pushes.
module cache_refill_arbiter #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_refill_if.master bus,
  output logic           busy,
  output logic           refill_err
);
  import cache_pkg::*;

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_REQ  = ST_REQ;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_PUSH = ST_PUSH;
  localparam logic [2:0] S_DONE = ST_DONE;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  owner_q, owner_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [7:0]            wdog_q, wdog_d;
  logic                  err_q, err_d;
  logic                  ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;
  logic [1:0]            grant;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({bus.dc_req, bus.ic_req}),
    .update_i (state_q == S_DONE),
    .owner_i  (owner_q),
    .grant_o  (grant)
  );

  // Next-state logic for the refill sequence and its datapath registers.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    owner_d  = owner_q;
    line_d   = line_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    ic_ack_d = 1'b0;
    dc_ack_d = 1'b0;
    case (state_q)
      S_IDLE: if (|grant) begin
        owner_d  = grant[1] ? OWN_DC : OWN_IC;
        addr_d   = line_align(grant[1] ? bus.dc_addr : bus.ic_addr);
        ic_ack_d = grant[0];
        dc_ack_d = grant[1];
        state_d  = S_REQ;
      end
      S_REQ: if (bus.mem_ready) begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.mem_rvalid) begin
          line_d  = bus.mem_rdata;
          state_d = S_PUSH;
        end else if (wdog_q == TO_LAST) begin
          // Memory never answered: flag it and release the requester without data.
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PUSH:  if (!bus.fifo_full) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      owner_q  <= OWN_IC;
      line_q   <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
      line_q   <= line_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      ic_ack_q <= ic_ack_d;
      dc_ack_q <= dc_ack_d;
    end
  end

  assign bus.ic_ack        = ic_ack_q;
  assign bus.dc_ack        = dc_ack_q;
  assign bus.ic_done       = (state_q == S_DONE) && (owner_q == OWN_IC);
  assign bus.dc_done       = (state_q == S_DONE) && (owner_q == OWN_DC);
  assign bus.mem_req       = (state_q == S_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.fifo_wr_en    = (state_q == S_PUSH) && !bus.fifo_full;
  assign bus.fifo_wr_data  = line_q;
  assign bus.fifo_wr_owner = owner_q;
  assign busy              = (state_q != S_IDLE);
  assign refill_err        = err_q;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed plus randomised refills checked against a transaction-level timing model.
module tb_cache_refill_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, refill_err;
  int   errors = 0;
  int   checks = 0;
  bit   last_dc = 1'b1;  // model: last served owner (1 = dcache), so icache wins after reset
  bit   err_m   = 1'b0;  // model: sticky timeout flag

  cache_refill_if #(.ADDR_WIDTH(32), .LINE_WIDTH(512)) bus ();

  cache_refill_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .refill_err (refill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ic_req = 0; bus.dc_req = 0; bus.ic_addr = '0; bus.dc_addr = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.fifo_full = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err"}, refill_err, 0);
    chk({tag, " mem_req"}, bus.mem_req, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " wr_en"}, bus.fifo_wr_en, 0);
    chk({tag, " wr_data"}, bus.fifo_wr_data, 0);
    chk({tag, " wr_owner"}, bus.fifo_wr_owner, 0);
    chk({tag, " acks"}, {bus.dc_ack, bus.ic_ack}, 0);
    chk({tag, " dones"}, {bus.dc_done, bus.ic_done}, 0);
  endtask

  // One miss transaction. rd = extra cycles before mem_ready, vd = WAIT cycles
  // before mem_rvalid, fc = PUSH cycles with fifo_full high, to = memory never answers.
  // Cycle 0 is the cycle in which the request is sampled.
  task automatic refill(input string tag, input bit ic, input bit dc,
                        input logic [31:0] ia, input logic [31:0] da,
                        input int rd, input int vd, input int fc, input bit to);
    bit w;
    logic [511:0] line;
    logic [31:0] ea;
    int t_wait, t_valid, t_push, t_wr, t_done;
    w = (ic && dc) ? !last_dc : dc;
    ea = (w ? da : ia) & 32'hFFFF_FFC0;
    for (int k = 0; k < 16; k++) line[k*32 +: 32] = $urandom();
    t_wait  = 2 + rd;
    t_valid = to ? -1 : t_wait + vd;
    t_push  = to ? -1 : t_valid + 1;
    t_wr    = to ? -1 : t_push + fc;
    t_done  = to ? t_wait + 255 : t_wr + 1;
    for (int c = 0; c <= t_done + 1; c++) begin
      @(posedge clk); #1;
      bus.ic_req     = (c == 0) && ic;
      bus.dc_req     = (c == 0) && dc;
      bus.ic_addr    = ia;
      bus.dc_addr    = da;
      bus.mem_ready  = (c == 1 + rd);
      // stray responses in REQ and DONE must be ignored
      bus.mem_rvalid = (c == t_valid) || (c == 1) || (c == t_done);
      bus.mem_rdata  = (c == t_valid) ? line : ~line;
      if (!to && c >= t_push && c <= t_wr) bus.fifo_full = (c < t_wr);
      else bus.fifo_full = $urandom_range(0, 1);
      @(negedge clk);
      chk({tag, " busy"}, busy, (c >= 1 && c <= t_done));
      chk({tag, " ack"}, {bus.dc_ack, bus.ic_ack}, (c == 1) ? {w, !w} : 2'b00);
      chk({tag, " mem_req"}, bus.mem_req, (c >= 1 && c <= 1 + rd));
      if (c >= 1 && c <= 1 + rd) chk({tag, " mem_addr"}, bus.mem_addr, ea);
      chk({tag, " wr_en"}, bus.fifo_wr_en, (c == t_wr));
      if (c == t_wr) begin
        chk({tag, " wr_data"}, bus.fifo_wr_data, line);
        chk({tag, " wr_owner"}, bus.fifo_wr_owner, w);
      end
      chk({tag, " done"}, {bus.dc_done, bus.ic_done}, (c == t_done) ? {w, !w} : 2'b00);
      chk({tag, " err"}, refill_err, err_m || (to && c >= t_done));
    end
    if (to) err_m = 1'b1;
    last_dc = w;
  endtask

  initial begin
    idle_inputs();
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // contention straight after reset: icache then dcache
    refill("both1", 1, 1, 32'h0000_1111, 32'h0000_2222, 0, 0, 0, 0);
    refill("both2", 1, 1, 32'h0000_3333, 32'h0000_4444, 0, 0, 0, 0);
    refill("ic_basic", 1, 0, 32'h0000_1234, 32'h0, 0, 0, 0, 0);
    refill("dc_basic", 0, 1, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    refill("fifo_full10", 1, 0, 32'hCAFE_F00D, 32'h0, 0, 0, 10, 0);
    refill("ready_dly7", 0, 1, 32'h0, 32'h8765_4321, 7, 0, 0, 0);
    refill("timeout", 1, 1, 32'h0000_0040, 32'h0000_0080, 0, 0, 0, 1);
    refill("after_to", 1, 1, 32'h1357_9BDF, 32'h2468_ACE0, 1, 2, 1, 0);

    for (int i = 0; i < 20; i++) begin
      bit ic, dc;
      ic = $urandom_range(0, 1);
      dc = ic ? bit'($urandom_range(0, 1)) : 1'b1;
      refill("rand", ic, dc, $urandom(), $urandom(), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // make icache the last served owner, then reset in the middle of WAIT
    refill("pre_rst", 1, 0, 32'h0000_5555, 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    bus.ic_req = 1; bus.ic_addr = 32'h0000_9999; bus.mem_ready = 1;
    @(posedge clk); #1; bus.ic_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    err_m = 1'b0; last_dc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1; bus.mem_rdata = {16{32'hA5A5_5A5A}};
      @(negedge clk);
      chk("post_rst wr_en", bus.fifo_wr_en, 0);
      chk("post_rst done", {bus.dc_done, bus.ic_done}, 0);
      chk("post_rst busy", busy, 0);
      chk("post_rst err", refill_err, 0);
    end
    idle_inputs();
    // round-robin pointer must be back to icache priority
    refill("post_rst_rr", 1, 1, 32'h0000_0ABC, 32'h0000_0DEF, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
